// File: rtl/rbm_pkg.sv
// Shared definitions for the RBM layers: FSM encoding, LFSR constants and
// the hard-sigmoid probability clamp.
package rbm_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    ACC    = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int unsigned LFSR_W = 16;
  // Right-shifting Fibonacci form of taps 16,14,13,11: feedback from bits 0,2,3,5
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

  // x/4 + 1/2 in sg_w-bit fixed point, saturated to [0, 2^sg_w - 1]
  function automatic int unsigned hard_sigmoid(input int signed acc,
                                               input int unsigned shift,
                                               input int unsigned sg_w);
    int signed x;
    int signed max_p;
    max_p = (32'sd1 <<< sg_w) - 32'sd1;
    x     = (acc >>> shift) + (32'sd1 <<< (sg_w - 32'd1));
    if (x < 32'sd0) begin
      return 32'd0;
    end
    if (x > max_p) begin
      return unsigned'(max_p);
    end
    return unsigned'(x);
  endfunction

endpackage

// File: rtl/rbm_lfsr.sv
// 16-bit Fibonacci LFSR that only steps when enabled; exposes its low out_w bits.
module rbm_lfsr
  import rbm_pkg::*;
#(
  parameter int unsigned out_w = LFSR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [LFSR_W-1:0] seed,
  output logic [out_w-1:0]  value
);

  logic [LFSR_W-1:0] state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= seed;
    end else if (enable) begin
      state <= {^(state & LFSR_TAPS), state[LFSR_W-1:1]};
    end
  end

  assign value = state[out_w-1:0];

endmodule

// File: rtl/rbm_visible_layer.sv
// RBM reconstruction layer: for each visible unit, sums weights of active hidden
// units onto its bias, maps the sum through a hard sigmoid and samples it.
module rbm_visible_layer
  import rbm_pkg::*;
#(
  parameter int unsigned       input_bitlength  = 12,
  parameter int unsigned       sg_bitlength     = 8,
  parameter int unsigned       output_bitlength = 12,
  parameter int unsigned       in_dim           = 15,
  parameter int unsigned       out_dim          = 5,
  parameter int unsigned       frac_bits        = 8,
  parameter logic [LFSR_W-1:0] lfsr_seed        = 16'hACE1
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic [out_dim-1:0]                       HiddenH,
  input  logic [in_dim*out_dim*input_bitlength-1:0] V_WeightI,
  input  logic [in_dim*input_bitlength-1:0]         V_BiasI,
  output logic [in_dim*output_bitlength-1:0]        VisibleP,
  output logic [in_dim-1:0]                         VisibleV,
  output logic                                      busy,
  output logic                                      done
);

  localparam int unsigned IW    = input_bitlength;
  localparam int unsigned SG    = sg_bitlength;
  localparam int unsigned OW    = output_bitlength;
  localparam int unsigned ACC_W = IW + $clog2(out_dim + 1);
  localparam int unsigned SHIFT = frac_bits + 2 - SG;
  localparam int unsigned IX_W  = (in_dim > 1) ? $clog2(in_dim) : 1;
  localparam int unsigned J_W   = (out_dim > 1) ? $clog2(out_dim) : 1;
  localparam int unsigned WX_W  = $clog2(in_dim * out_dim + 1);

  localparam logic [IX_W-1:0] I_LAST = IX_W'(in_dim - 1);
  localparam logic [J_W-1:0]  J_LAST = J_W'(out_dim - 1);

  // Unpacked views of the flat weight/bias buses
  logic signed [IW-1:0] w_arr [in_dim*out_dim];
  logic signed [IW-1:0] b_arr [in_dim];

  for (genvar k = 0; k < in_dim * out_dim; k++) begin : g_w
    assign w_arr[k] = V_WeightI[k*IW +: IW];
  end
  for (genvar k = 0; k < in_dim; k++) begin : g_b
    assign b_arr[k] = V_BiasI[k*IW +: IW];
  end

  state_t                    state, state_d;
  logic [out_dim-1:0]        h_q;
  logic [IX_W-1:0]           i_q;
  logic [J_W-1:0]            j_q;
  logic [WX_W-1:0]           widx_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic [OW-1:0]             p_q [in_dim];
  logic [in_dim-1:0]         v_q;
  logic                      busy_q;
  logic                      done_q;
  logic [SG-1:0]             rnd_c;
  logic [SG-1:0]             p_c;
  logic                      samp_c;
  logic                      lfsr_en_c;
  logic [IX_W-1:0]           i_nxt_c;

  rbm_lfsr #(.out_w(SG)) u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .enable (lfsr_en_c),
    .seed   (lfsr_seed),
    .value  (rnd_c)
  );

  assign lfsr_en_c = (state == SAMPLE);
  assign p_c       = SG'(hard_sigmoid(int'(acc_q), SHIFT, SG));
  assign samp_c    = (rnd_c < p_c);
  assign i_nxt_c   = i_q + IX_W'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // A start seen while done is still high belongs to the finished pass
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (start && !done_q) state_d = LOAD;
      LOAD:    state_d = ACC;
      ACC:     if (j_q == J_LAST) state_d = SAMPLE;
      SAMPLE:  state_d = (i_q == I_LAST) ? DONE : ACC;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      h_q    <= '0;
      i_q    <= '0;
      j_q    <= '0;
      widx_q <= '0;
      acc_q  <= '0;
      v_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      for (int k = 0; k < int'(in_dim); k++) begin
        p_q[k] <= '0;
      end
    end else begin
      busy_q <= (state == LOAD) || (state == ACC) || (state == SAMPLE);
      done_q <= (state == DONE);
      case (state)
        IDLE: begin
          if (start && !done_q) h_q <= HiddenH;
        end
        LOAD: begin
          i_q    <= '0;
          j_q    <= '0;
          widx_q <= '0;
          acc_q  <= ACC_W'(b_arr[0]);
        end
        ACC: begin
          if (h_q[j_q]) acc_q <= acc_q + ACC_W'(w_arr[widx_q]);
          j_q    <= j_q + J_W'(1);
          widx_q <= widx_q + WX_W'(1);
        end
        SAMPLE: begin
          p_q[i_q] <= OW'(p_c);
          v_q[i_q] <= samp_c;
          if (i_q != I_LAST) begin
            i_q   <= i_nxt_c;
            j_q   <= '0;
            acc_q <= ACC_W'(b_arr[i_nxt_c]);
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < in_dim; k++) begin : g_p
    assign VisibleP[k*OW +: OW] = p_q[k];
  end
  assign VisibleV = v_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_rbm_visible_layer.sv
// Directed bench for rbm_visible_layer: pass timing, saturation, latched hidden
// vector, LFSR-driven sampling, ignored starts and mid-pass reset.
module tb_rbm_visible_layer;

  localparam int IN = 15;
  localparam int OUT = 5;
  localparam int IW = 12;
  localparam int OW = 12;
  localparam logic [15:0] SEED = 16'hACE1;

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic [OUT-1:0]        hid;
  logic [IN*OUT*IW-1:0]  wt;
  logic [IN*IW-1:0]      bs;
  logic [IN*OW-1:0]      vp;
  logic [IN-1:0]         vv;
  logic                  busy;
  logic                  done;

  int vectors = 0;
  int errors = 0;
  logic [15:0] m_lfsr;
  logic [IN-1:0] exp_v;
  logic [IN*OW-1:0] exp_p;
  int done_n, busy_err, done_cnt;

  rbm_visible_layer #(
    .input_bitlength(12), .sg_bitlength(8), .output_bitlength(12),
    .in_dim(IN), .out_dim(OUT), .frac_bits(8), .lfsr_seed(SEED)
  ) dut (
    .clock(clk), .reset(rst_n), .start(start), .HiddenH(hid),
    .V_WeightI(wt), .V_BiasI(bs), .VisibleP(vp), .VisibleV(vv),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_weights(input logic [IW-1:0] w, input bit rnd);
    for (int k = 0; k < IN * OUT; k++) wt[k*IW +: IW] = rnd ? IW'($urandom) : w;
  endtask

  task automatic set_bias(input logic [IW-1:0] b);
    for (int k = 0; k < IN; k++) bs[k*IW +: IW] = b;
  endtask

  // Expected samples for a pass where every unit has probability p
  task automatic model_pass(input logic [7:0] p);
    for (int k = 0; k < IN; k++) begin
      exp_v[k] = (m_lfsr[7:0] < p);
      m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
      exp_p[k*OW +: OW] = OW'(p);
    end
  endtask

  // One pass; observations taken at negedges after edge t0+n
  task automatic run_pass(input logic [OUT-1:0] h, input int inj_n, input bit b2b,
                          input int abort_n);
    done_n = 0; busy_err = 0; done_cnt = 0;
    @(negedge clk); hid = h; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0; hid = ~h;
    if (busy !== 1'b0) busy_err++;
    for (int n = 1; n <= 94; n++) begin
      @(negedge clk);
      if (abort_n != 0 && n == abort_n - 1) begin
        rst_n = 1'b0;
        break;
      end
      if (busy !== ((n <= 91) ? 1'b1 : 1'b0)) busy_err++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_n == 0) done_n = n;
      end
      if (n == inj_n - 1) start = 1'b1;
      if (n == inj_n) start = 1'b0;
      if (b2b && n == 92) start = 1'b1;
      if (b2b && n == 93) start = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; hid = '0; wt = '0; bs = '0;
    m_lfsr = SEED;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++; if (vp !== '0) begin errors++; $display("FAIL reset_p got %h want 0", vp); end
    vectors++; if (vv !== '0) begin errors++; $display("FAIL reset_v got %h want 0", vv); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero;
    set_weights('0, 1'b0); set_bias('0);
    model_pass(8'd128);
    run_pass(5'b10110, 0, 1'b0, 0);
    vectors++; if (done_n != 92) begin errors++; $display("FAIL zero_done_at got %0d want 92", done_n); end
    vectors++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_len got %0d want 1", done_cnt); end
    vectors++; if (busy_err != 0) begin errors++; $display("FAIL zero_busy bad_cycles %0d want 0", busy_err); end
    vectors++; if (vp !== exp_p) begin errors++; $display("FAIL zero_p got %h want %h", vp, exp_p); end
    vectors++; if (vv !== exp_v) begin errors++; $display("FAIL zero_v got %b want %b", vv, exp_v); end
  endtask

  task automatic test_saturate_high;
    set_weights(12'h100, 1'b0); set_bias('0);
    model_pass(8'd255);
    run_pass(5'b11111, 0, 1'b0, 0);
    vectors++; if (done_n != 92) begin errors++; $display("FAIL sat_done_at got %0d want 92", done_n); end
    vectors++; if (vp !== exp_p) begin errors++; $display("FAIL sat_p got %h want %h", vp, exp_p); end
    vectors++; if (vv !== exp_v) begin errors++; $display("FAIL sat_v got %b want %b", vv, exp_v); end
  endtask

  task automatic test_saturate_low;
    set_weights(12'hF00, 1'b0); set_bias('0);
    model_pass(8'd0);
    run_pass(5'b11111, 0, 1'b0, 0);
    vectors++; if (done_n != 92) begin errors++; $display("FAIL neg_done_at got %0d want 92", done_n); end
    vectors++; if (vp !== '0) begin errors++; $display("FAIL neg_p got %h want 0", vp); end
    vectors++; if (vv !== '0) begin errors++; $display("FAIL neg_v got %b want 0", vv); end
  endtask

  task automatic test_bias_only;
    set_weights('0, 1'b1); set_bias(12'h040);
    model_pass(8'd144);
    run_pass(5'b00000, 0, 1'b0, 0);
    vectors++; if (done_n != 92) begin errors++; $display("FAIL bias_done_at got %0d want 92", done_n); end
    vectors++; if (vp !== exp_p) begin errors++; $display("FAIL bias_p got %h want %h", vp, exp_p); end
    vectors++; if (vv !== exp_v) begin errors++; $display("FAIL bias_v got %b want %b", vv, exp_v); end
  endtask

  task automatic test_back_to_back;
    set_weights('0, 1'b0); set_bias('0);
    model_pass(8'd128);
    run_pass(5'b01010, 10, 1'b1, 0);
    vectors++; if (done_n != 92) begin errors++; $display("FAIL b2b_done_at got %0d want 92", done_n); end
    vectors++; if (busy_err != 0) begin errors++; $display("FAIL b2b_busy bad_cycles %0d want 0", busy_err); end
    vectors++; if (vp !== exp_p) begin errors++; $display("FAIL b2b_p got %h want %h", vp, exp_p); end
    vectors++; if (vv !== exp_v) begin errors++; $display("FAIL b2b_v got %b want %b", vv, exp_v); end
    repeat (3) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_abort;
    set_weights(12'h100, 1'b0); set_bias('0);
    run_pass(5'b11111, 10, 1'b0, 30);
    m_lfsr = SEED;
    @(negedge clk);
    vectors++; if (vp !== '0) begin errors++; $display("FAIL abort_p got %h want 0", vp); end
    vectors++; if (vv !== '0) begin errors++; $display("FAIL abort_v got %h want 0", vv); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_restart_busy got %b want 0", busy); end
    set_weights('0, 1'b0);
    model_pass(8'd128);
    run_pass(5'b11111, 0, 1'b0, 0);
    vectors++; if (done_n != 92) begin errors++; $display("FAIL rerun_done_at got %0d want 92", done_n); end
    vectors++; if (vp !== exp_p) begin errors++; $display("FAIL rerun_p got %h want %h", vp, exp_p); end
    vectors++; if (vv !== exp_v) begin errors++; $display("FAIL rerun_v got %b want %b", vv, exp_v); end
  endtask

  initial begin
    test_reset;
    test_zero;
    test_saturate_high;
    test_saturate_low;
    test_bias_only;
    test_back_to_back;
    test_abort;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/rbm_visible_layer.md
RBM_VISIBLE_LAYER -- requirements
Module: rbm_visible_layer

Interface
REQ-001 The block SHALL have parameter input_bitlength, default 12, signed two's-complement width of weights and biases.
REQ-002 The block SHALL have parameter sg_bitlength, default 8, width of the unsigned probability and of the random compare word.
REQ-003 The block SHALL have parameter output_bitlength, default 12, width of each probability output field (probability zero-extended).
REQ-004 The block SHALL have parameters in_dim, default 15 (visible units), and out_dim, default 5 (hidden units).
REQ-005 The block SHALL have parameter frac_bits, default 8, fractional bits of weights and biases, with frac_bits+2 >= sg_bitlength.
REQ-006 The block SHALL have parameter lfsr_seed, default 16'hACE1, which must be nonzero.
REQ-007 The block SHALL have port clock, input, 1 bit, single clock, rising edge.
REQ-008 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-009 The block SHALL have port start, input, 1 bit, pulse that requests one reconstruction pass.
REQ-010 The block SHALL have port HiddenH, input, out_dim bits, binary hidden vector.
REQ-011 The block SHALL have port V_WeightI, input, in_dim*out_dim*input_bitlength bits, weight W[i][j] packed at flat index i*out_dim+j, the same layout as the forward RBM layer.
REQ-012 The block SHALL have port V_BiasI, input, in_dim*input_bitlength bits, visible biases.
REQ-013 The block SHALL have port VisibleP, output, in_dim*output_bitlength bits, per-unit probability.
REQ-014 The block SHALL have port VisibleV, output, in_dim bits, per-unit sampled visible state.
REQ-015 The block SHALL have ports busy and done, outputs, 1 bit each.

Function
REQ-016 The block SHALL implement FSM states IDLE, LOAD, ACC, SAMPLE and DONE.
REQ-017 In IDLE, start=1 at a clock edge SHALL latch HiddenH and move to LOAD.
REQ-018 In LOAD (one cycle), the block SHALL set i=0, j=0 and acc=sign-extended bias[0], then move to ACC.
REQ-019 In ACC (out_dim cycles), each cycle the block SHALL add sign-extended W[i][j] to acc if h[j]=1 (no multiplier) and increment j; after j=out_dim-1 it SHALL move to SAMPLE.
REQ-020 acc SHALL be input_bitlength+$clog2(out_dim+1) bits and SHALL never overflow.
REQ-021 In SAMPLE (one cycle), p SHALL be clamp((acc >>> (frac_bits+2-sg_bitlength)) + 2^(sg_bitlength-1), 0, 2^sg_bitlength-1), i.e. hard sigmoid x/4+1/2.
REQ-022 In SAMPLE, the block SHALL write VisibleP[i]=p and VisibleV[i]=(lfsr[sg_bitlength-1:0] < p), then advance the LFSR once.
REQ-023 After SAMPLE, if i<in_dim-1 the block SHALL set i++, j=0, acc=bias[i+1] and return to ACC; otherwise it SHALL move to DONE.
REQ-024 DONE SHALL last one cycle with done=1 and then return to IDLE.
REQ-025 busy SHALL be 1 in LOAD, ACC and SAMPLE, and 0 otherwise.
REQ-026 With start accepted at edge t0, done SHALL be high in the cycle following edge t0+2+in_dim*(out_dim+1) (t0+92 at defaults).
REQ-027 start SHALL be ignored in every state except IDLE; a start coincident with done SHALL be ignored.
REQ-028 V_WeightI and V_BiasI SHALL be required stable while busy; HiddenH changes after the start edge SHALL have no effect.
REQ-029 Outputs SHALL hold their values between passes; VisibleP/VisibleV[k] SHALL update only in the SAMPLE state for k.
REQ-030 The LFSR SHALL be 16-bit Fibonacci with taps 16,14,13,11, and SHALL NOT advance outside SAMPLE.

Reset
REQ-031 While reset=0, the block SHALL asynchronously force state IDLE, busy=0, done=0, VisibleP=0, VisibleV=0, acc=0, i=j=0 and lfsr=lfsr_seed.
REQ-032 A reset asserted mid-pass SHALL abort the pass, and the next pass after release SHALL require a new start.

Structure
REQ-033 A shared package rbm_pkg SHALL hold the FSM state encoding, the LFSR width/taps constants and the hard-sigmoid clamp function.
REQ-034 The LFSR SHALL be a sub-module rbm_lfsr (ports clock, reset, enable, seed, value) so it can be shared with the forward layer.

Verification
REQ-035 The bench SHALL apply all W=0, bias=0 and start -> all VisibleP=128, done at t0+92, busy high t0+1..t0+91.
REQ-036 The bench SHALL apply HiddenH=5'b11111, all W=12'h100, bias 0 -> acc=1280, all VisibleP=255 (saturated).
REQ-037 The bench SHALL apply HiddenH=5'b11111, all W=12'hF00 -> all VisibleP=0 and VisibleV=0.
REQ-038 The bench SHALL apply HiddenH=0, random W, bias[i]=12'h040 -> all VisibleP=144, W ignored.
REQ-039 The bench SHALL apply all p=128 -> VisibleV matches a model LFSR from seed 16'hACE1, bit i = (byte of i-th state < 128).
REQ-040 The bench SHALL pulse start at t0+10 (ignored, done still at t0+92), then assert reset at t0+30 -> all outputs 0 and IDLE, and after release a new start gives a full pass with LFSR restarted from seed.
